tdm_demux4: RTL and testbench

- 1-to-4 time-division demultiplexer. It is the receive end of the 4:1 mux path.
- Takes a bit-interleaved serial stream: one bit per beat, channel order a,b,c,d = slots 0..3.
- Rebuilds a WIDTH-bit parallel word for each of the four channels.
- Sits after the 4:1 mux link and drives the four per-channel consumers.

---
 rtl/tdm_demux4.sv | 96 +++++++++
 tb/tb_tdm_demux4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 1-to-4 bit-interleaved TDM demultiplexer, MSB-first word rebuild per channel
// Optional macro TDM_DEMUX_PARITY_EN: even-parity bit after each word, adds parity_err[3:0].
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [1:0]           sel,
  output logic [4*WIDTH-1:0]   dout,
  output logic [3:0]           dout_valid,
  output logic                 sync_err,
`ifdef TDM_DEMUX_PARITY_EN
  output logic [3:0]           parity_err,
`endif
  output logic                 locked
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // SW = serial bits per channel word, including the parity bit when enabled
  localparam int SW   = WIDTH + PAR;
  localparam int CW   = $clog2(SW);
  localparam int LAST = SW - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   shreg [4];
  logic [CW-1:0]   bitcnt;
  logic [SW-1:0]   shin;
  logic            start;
  logic            shift;
  logic            at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    shin    = {shreg[sel][SW-2:0], din};
    at_last = (bitcnt == CW'(LAST));
    // A frame_sync anywhere but slot 0 (or while unlocked) restarts the frame on this beat
    start   = din_valid && frame_sync && ((state == IDLE) || (sel != 2'd0));
    shift   = din_valid && (state == RUN) && !start;
    if (start) state_n = RUN;
  end

  assign locked = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 2'd0;
      bitcnt     <= '0;
      dout       <= '0;
      dout_valid <= 4'd0;
      sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 4'd0;
`endif
      for (int k = 0; k < 4; k++) shreg[k] <= '0;
    end else begin
      dout_valid <= 4'd0;
      sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err <= 4'd0;
`endif
      if (start) begin
        for (int k = 1; k < 4; k++) shreg[k] <= '0;
        shreg[0] <= {{(SW-1){1'b0}}, din};
        bitcnt   <= '0;
        sel      <= 2'd1;
        sync_err <= (state == RUN);
      end else if (shift) begin
        shreg[sel] <= shin;
        sel        <= sel + 2'd1;
        if (sel == 2'd3) bitcnt <= at_last ? '0 : bitcnt + CW'(1);
        if (at_last) begin
          dout[int'(sel)*WIDTH +: WIDTH] <= shin[SW-1 -: WIDTH];
          dout_valid[sel]                <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
          parity_err[sel]                <= ^shin;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed and random checks of tdm_demux4 against a frame-position model
module tb_tdm_demux4;

  localparam int W = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SW = W + PAR;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            din = 1'b0;
  logic            din_valid = 1'b0;
  logic            frame_sync = 1'b0;
  logic [1:0]      sel;
  logic [4*W-1:0]  dout;
  logic [3:0]      dout_valid;
  logic            sync_err;
  logic            locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic [3:0]      parity_err;
`endif

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .sel(sel), .dout(dout), .dout_valid(dout_valid),
    .sync_err(sync_err),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one position counter over the whole frame (4*SW beats) instead of slot/bit counters
  bit         m_locked = 0;
  int         m_pos = 0;
  int         m_acc [4] = '{0, 0, 0, 0};
  logic [7:0] m_dout [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic [3:0] m_dv = 4'd0;
  logic [3:0] m_pe = 4'd0;
  logic       m_se = 1'b0;
  int         beat_no = 0;
  int         dut_a_last = -1000;
  int         dut_a_gap = 0;
  int         se_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_pos = 0; m_dv = 4'd0; m_pe = 4'd0; m_se = 1'b0;
    for (int k = 0; k < 4; k++) begin m_acc[k] = 0; m_dout[k] = 8'h0; end
  endtask

  task automatic model_step();
    int ch;
    m_dv = 4'd0; m_pe = 4'd0; m_se = 1'b0;
    if (!rst_n || !din_valid) return;
    beat_no++;
    if (frame_sync && (!m_locked || (m_pos % 4) != 0)) begin
      m_se = m_locked;
      m_locked = 1;
      for (int k = 0; k < 4; k++) m_acc[k] = 0;
      m_acc[0] = int'(din);
      m_pos = 1;
    end else if (m_locked) begin
      ch = m_pos % 4;
      m_acc[ch] = ((m_acc[ch] << 1) | int'(din)) & ((1 << SW) - 1);
      if (m_pos / 4 == SW - 1) begin
        m_dout[ch] = 8'(m_acc[ch] >> PAR);
        m_dv[ch] = 1'b1;
        m_pe[ch] = ($countones(m_acc[ch]) % 2) == 1;
      end
      m_pos = (m_pos + 1) % (4 * SW);
    end
  endtask

  task automatic compare();
    chk("sel", sel, m_locked ? 2'(m_pos % 4) : 2'd0);
    chk("dout", dout, {m_dout[3], m_dout[2], m_dout[1], m_dout[0]});
    chk("dout_valid", dout_valid, m_dv);
    chk("sync_err", sync_err, m_se);
    chk("locked", locked, m_locked);
`ifdef TDM_DEMUX_PARITY_EN
    chk("parity_err", parity_err, m_pe);
`endif
    if (dout_valid[0]) begin dut_a_gap = beat_no - dut_a_last; dut_a_last = beat_no; end
    if (sync_err) se_seen++;
  endtask

  task automatic cycle(input logic v, input logic d, input logic fs);
    din_valid = v; din = d; frame_sync = fs;
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  task automatic send_frame(input logic [31:0] words, input logic [3:0] pb, input bit fs_first, input bit gaps);
    logic [8:0] ext;
    for (int i = 0; i < SW; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (PAR == 1) ext = {words[ch*8 +: 8], pb[ch]};
        else          ext = {1'b0, words[ch*8 +: 8]};
        if (gaps) cycle(1'b0, 1'($urandom), 1'($urandom));
        cycle(1'b1, ext[SW-1-i], fs_first && i == 0 && ch == 0);
      end
    end
  endtask

  function automatic logic [3:0] good_par(input logic [31:0] w);
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
  endfunction

  initial begin
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    repeat (3) cycle(1'b1, 1'($urandom), 1'b0);

    send_frame(32'h00FF3CA5, good_par(32'h00FF3CA5), 1, 0);
    chk("basic_dout", dout, 32'h00FF3CA5);
    repeat (2) cycle(1'b0, 1'b1, 1'b1);

    send_frame(32'h00FF3CA5, good_par(32'h00FF3CA5), 1, 1);
    chk("gapped_dout", dout, 32'h00FF3CA5);

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom), 1'b0);
    chk("resync_sel", sel, 2'd2);
    se_seen = 0;
    send_frame(32'h11223344, good_par(32'h11223344), 1, 0);
    chk("resync_pulse", se_seen, 1);
    chk("resync_dout", dout, 32'h11223344);

    send_frame(32'h9C5A6B00, good_par(32'h9C5A6B00), 1, 0);
    send_frame(32'h9C5A6B01, good_par(32'h9C5A6B01), 0, 0);
    chk("wrap_gap", dut_a_gap, 4 * SW);
    chk("wrap_dout", dout, 32'h9C5A6B01);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(32'h00000007, 4'b0000, 1, 0);
    send_frame(32'h00000007, 4'b0001, 1, 0);
`endif

    for (int i = 0; i < 13; i++) cycle(1'b1, 1'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", sel, 2'd0);
    chk("arst_dout", dout, 32'h0);
    chk("arst_dv", dout_valid, 4'd0);
    chk("arst_locked", locked, 1'b0);
    chk("arst_sync_err", sync_err, 1'b0);
    model_reset();
    repeat (2) cycle(1'b1, 1'($urandom), 1'b0);
    rst_n = 1'b1;
    repeat (40) cycle(1'b1, 1'($urandom), 1'b0);
    chk("no_relock", locked, 1'b0);

    for (int i = 0; i < 2500; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom),
            ((m_pos % 4 == 0) && $urandom_range(0, 15) == 0) || $urandom_range(0, 119) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
